// File: rtl/bounce_generator_if.sv
// Request/status bundle between a bounce_generator and whatever drives it.
// The master side issues start/target; the slave side is the generator itself.
interface bounce_generator_if;
  logic       target;
  logic       start;
  logic       noisysignal;
  logic       busy;
  logic       done;
  logic [7:0] bounce_count;

  modport master (
    output target, start,
    input  noisysignal, busy, done, bounce_count
  );

  modport slave (
    input  target, start,
    output noisysignal, busy, done, bounce_count
  );
endinterface

// File: rtl/bounce_generator.sv
// Drives a 1-bit line to a requested level through an LFSR-driven burst of
// contact-bounce glitches, then holds it clean for a settle window before pulsing done.
module bounce_generator #(
  parameter int         BOUNCE_CYCLES = 16,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         CNT_WIDTH     = 8,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  bounce_generator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  // A settle window of zero still needs one cycle to emit done.
  localparam logic [CNT_WIDTH-1:0] BOUNCE_LAST =
    CNT_WIDTH'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST =
    CNT_WIDTH'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);

  state_t               r_state, w_state;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
  logic [7:0]           r_lfsr, w_lfsr;
  logic [7:0]           r_bounceCount, w_bounceCount;
  logic                 r_noisy, w_noisy;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_target, w_target;
  logic [7:0]           w_lfsrShift;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, feedback entering at bit 0.
  assign w_lfsrShift = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_lfsr        <= LFSR_SEED;
      r_bounceCount <= '0;
      r_noisy       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_target      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_lfsr        <= w_lfsr;
      r_bounceCount <= w_bounceCount;
      r_noisy       <= w_noisy;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_target      <= w_target;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_lfsr        = r_lfsr;
    w_bounceCount = r_bounceCount;
    w_noisy       = r_noisy;
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_target      = r_target;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.target == r_noisy) begin
            w_done        = 1'b1;
            w_bounceCount = '0;
          end else begin
            w_target      = bus.target;
            w_busy        = 1'b1;
            w_cnt         = '0;
            w_bounceCount = '0;
            if (BOUNCE_CYCLES == 0) begin
              w_noisy = bus.target;
              w_state = SETTLE;
            end else begin
              w_state = BOUNCE;
            end
          end
        end
      end

      BOUNCE: begin
        w_lfsr = w_lfsrShift;
        // The final burst cycle forces the target instead of risking one more glitch.
        if (r_cnt == BOUNCE_LAST) begin
          w_noisy = r_target;
          w_cnt   = '0;
          w_state = SETTLE;
        end else begin
          if (r_lfsr[0]) begin
            w_noisy = ~r_noisy;
            if (r_bounceCount != 8'hFF) begin
              w_bounceCount = r_bounceCount + 8'd1;
            end
          end
          w_cnt = r_cnt + CNT_WIDTH'(1);
        end
      end

      SETTLE: begin
        w_noisy = r_target;
        if (r_cnt == SETTLE_LAST) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_cnt   = '0;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + CNT_WIDTH'(1);
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign bus.noisysignal  = r_noisy;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.bounce_count = r_bounceCount;

endmodule

// File: tb/tb_bounce_generator.sv
// Scoreboard bench: a bursty instance (16/8) and a clean-edge instance (0/8) share clock
// and reset; a reference model predicts line, busy, done and bounce_count per clock edge.
module tb_bounce_generator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edgeCount = 0;
  bit   monitorOn = 1'b0;
  int   assertions = 0;
  int   failures = 0;

  bounce_generator_if bif0 ();
  bounce_generator_if bif1 ();

  bounce_generator #(.BOUNCE_CYCLES(16), .SETTLE_CYCLES(8), .CNT_WIDTH(8), .LFSR_SEED(8'hA5))
    dut0 (.clk(clk), .reset(reset), .bus(bif0));

  bounce_generator #(.BOUNCE_CYCLES(0), .SETTLE_CYCLES(8), .CNT_WIDTH(8), .LFSR_SEED(8'hA5))
    dut1 (.clk(clk), .reset(reset), .bus(bif1));

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Reference model state, one slot per instance.
  int         bCyc[2] = '{16, 0};
  int         sCyc[2] = '{8, 8};
  logic [7:0] modelLfsr[2];
  logic       modelLevel[2];
  logic [7:0] modelCount[2];
  int         busyFrom[2];
  int         busyTo[2];
  logic       expLine[int];
  logic [7:0] expDone[int];

  function automatic int keyOf(int id, int e);
    return id * 1000000 + e;
  endfunction

  function automatic logic [7:0] lfsrStep(logic [7:0] v);
    int taps;
    taps = int'(v[7]) + int'(v[5]) + int'(v[4]) + int'(v[3]);
    return 8'((int'(v) * 2 + taps % 2) % 256);
  endfunction

  task automatic checkOutput(string name, int id, int e, logic [7:0] act, logic [7:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d edge %0d: got %0h expected %0h", name, id, e, act, exp);
    end
  endtask

  task automatic checkCycle(int id, logic line, logic busy, logic done, logic [7:0] cnt);
    int   e;
    int   k;
    logic exL;
    logic exB;
    logic exD;
    e   = edgeCount;
    k   = keyOf(id, e);
    exL = expLine.exists(k) ? expLine[k] : modelLevel[id];
    exB = (e >= busyFrom[id]) && (e < busyTo[id]);
    exD = expDone.exists(k);
    checkOutput("noisysignal", id, e, {7'd0, line}, {7'd0, exL});
    checkOutput("busy", id, e, {7'd0, busy}, {7'd0, exB});
    checkOutput("done", id, e, {7'd0, done}, {7'd0, exD});
    if (exD) begin
      checkOutput("bounce_count_at_done", id, e, cnt, expDone[k]);
      expDone.delete(k);
    end else if (e >= busyTo[id]) begin
      checkOutput("bounce_count_idle", id, e, cnt, modelCount[id]);
    end
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      checkCycle(0, bif0.noisysignal, bif0.busy, bif0.done, bif0.bounce_count);
      checkCycle(1, bif1.noisysignal, bif1.busy, bif1.done, bif1.bounce_count);
    end
  end

  task automatic modelReset();
    for (int id = 0; id < 2; id++) begin
      modelLfsr[id]  = 8'hA5;
      modelLevel[id] = 1'b0;
      modelCount[id] = 8'd0;
      busyFrom[id]   = 0;
      busyTo[id]     = 0;
    end
    expLine.delete();
    expDone.delete();
  endtask

  // Predicts the response to a start sampled at edge k, if the generator was free.
  task automatic modelStart(int id, logic t, int k);
    int         b;
    int         s;
    logic       lvl;
    logic [7:0] cnt;
    if ((k - 1 >= busyFrom[id]) && (k - 1 < busyTo[id])) return;
    b = bCyc[id];
    s = (sCyc[id] > 0) ? sCyc[id] : 1;
    if (t == modelLevel[id]) begin
      modelCount[id]        = 8'd0;
      busyFrom[id]          = k;
      busyTo[id]            = k;
      expDone[keyOf(id, k)] = 8'd0;
    end else if (b == 0) begin
      modelLevel[id]            = t;
      modelCount[id]            = 8'd0;
      busyFrom[id]              = k;
      busyTo[id]                = k + s;
      expDone[keyOf(id, k + s)] = 8'd0;
    end else begin
      lvl = modelLevel[id];
      cnt = 8'd0;
      expLine[keyOf(id, k)] = lvl;
      for (int i = 0; i < b; i++) begin
        if (i < b - 1) begin
          if (modelLfsr[id][0]) begin
            lvl = ~lvl;
            if (cnt < 8'd255) cnt = cnt + 8'd1;
          end
          expLine[keyOf(id, k + 1 + i)] = lvl;
        end
        modelLfsr[id] = lfsrStep(modelLfsr[id]);
      end
      modelLevel[id]                = t;
      modelCount[id]                = cnt;
      busyFrom[id]                  = k;
      busyTo[id]                    = k + b + s;
      expDone[keyOf(id, k + b + s)] = cnt;
    end
  endtask

  task automatic driveStart(int id, logic s, logic t);
    if (id == 0) begin
      bif0.start  = s;
      bif0.target = t;
    end else begin
      bif1.start  = s;
      bif1.target = t;
    end
  endtask

  task automatic applyStimulus(int id, logic t);
    int k;
    driveStart(id, 1'b1, t);
    @(posedge clk);
    #1;
    driveStart(id, 1'b0, t);
    k = edgeCount;
    modelStart(id, t, k);
  endtask

  task automatic applyReset(int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      modelReset();
      monitorOn = 1'b1;
    end
    reset = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    driveStart(0, 1'b1, 1'b1);
    driveStart(1, 1'b1, 1'b1);
    applyReset(2);
    driveStart(0, 1'b0, 1'b0);
    driveStart(1, 1'b0, 1'b0);
    idle(3);

    $display("[TB] same-level request");
    applyStimulus(0, 1'b0);
    applyStimulus(1, 1'b0);
    idle(3);

    $display("[TB] bounced rise and clean rise");
    applyStimulus(0, 1'b1);
    applyStimulus(1, 1'b1);
    idle(30);

    $display("[TB] start during burst is dropped");
    applyStimulus(0, 1'b0);
    idle(4);
    applyStimulus(0, 1'b1);
    idle(30);

    $display("[TB] reset mid-burst then replay");
    applyStimulus(0, 1'b1);
    idle(4);
    applyReset(1);
    idle(2);
    applyStimulus(0, 1'b1);
    idle(30);

    $display("[TB] randomized requests");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 28)));
    end
    idle(40);

    assertions++;
    if (expDone.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_done: got %0d outstanding expected 0", expDone.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
